// File: rtl/fp_mult_result_fifo.sv
// fp_mult_result_fifo
//   Result buffer behind the single-precision FP multiplier. Each accepted
//   product word is stored together with its 8-bit status byte and a
//   destination tag. The writeback stage can therefore stall without
//   back-pressuring the multiplier issue logic. A sticky OR of every pushed
//   status byte is kept for the control unit, which clears it with flag_clr.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : push handshake; in_ready depends only on the registered count
//   in_z/in_status/in_tag : product word, status byte, destination tag
//   out_valid/out_ready : pop handshake for the head entry
//   out_z/out_status/out_tag : head entry; driven to zero while empty
//   count               : occupancy, 0..DEPTH
//   flag_clr            : clears sticky_flags (a push in the same cycle still sets bits)
//   sticky_flags        : OR of the status bytes pushed since the last clear/reset
//
// Optional feature (macro FP_MULT_RESULT_FIFO_IRQ_EN)
//   flag_mask (in, 8)   : selects which sticky bits raise the interrupt
//   flag_irq  (out, 1)  : registered |(sticky_flags & flag_mask)
//
// Status byte: bit0 zero, bit1 inf, bit2 invalid, bit3 tiny, bit4 huge,
//              bit5 inexact, bit6 hugeint, bit7 reserved.

module fp_mult_result_fifo #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_z,
  input  logic [7:0]                     in_status,
  input  logic [TAG_WIDTH-1:0]           in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   out_z,
  output logic [7:0]                     out_status,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]         count,
  input  logic                           flag_clr,
  output logic [7:0]                     sticky_flags
`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
  ,
  input  logic [7:0]                     flag_mask,
  output logic                           flag_irq
`endif
);

  localparam int Z_W   = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = Z_W + 8 + TAG_WIDTH;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       sticky_q;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage: data only, no reset. Stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_z, in_status, in_tag};
    end
  end

  // Control: pointers wrap naturally (DEPTH is a power of two); count alone
  // tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Set wins over clear: a byte pushed alongside flag_clr survives.
      sticky_q <= (flag_clr ? 8'h00 : sticky_q) | (push ? in_status : 8'h00);
    end
  end

  assign head         = mem[rd_ptr];
  assign out_z        = out_valid ? head[ENT_W-1 -: Z_W]        : '0;
  assign out_status   = out_valid ? head[TAG_WIDTH +: 8]        : '0;
  assign out_tag      = out_valid ? head[TAG_WIDTH-1:0]         : '0;
  assign count        = count_q;
  assign sticky_flags = sticky_q;

`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
  // Registered from the registered flags: one cycle behind sticky_flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_irq <= 1'b0;
    else     flag_irq <= |(sticky_q & flag_mask);
  end
`endif

endmodule

// File: tb/tb_fp_mult_result_fifo.sv
module tb_fp_mult_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic [3:0]  out_tag;
  logic [2:0]  count;
  logic        flag_clr;
  logic [7:0]  sticky_flags;
`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
  logic [7:0]  flag_mask;
  logic        flag_irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mult_result_fifo #(
    .SIG_WIDTH(23), .EXP_WIDTH(8), .TAG_WIDTH(4), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_status(in_status), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_status(out_status), .out_tag(out_tag),
    .count(count), .flag_clr(flag_clr), .sticky_flags(sticky_flags)
`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
    , .flag_mask(flag_mask), .flag_irq(flag_irq)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] z, input logic [7:0] st,
                       input logic [3:0] tg, input logic ordy, input logic clr);
    in_valid  = v;
    in_z      = z;
    in_status = st;
    in_tag    = tg;
    out_ready = ordy;
    flag_clr  = clr;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({out_z, out_status, out_tag} !== 44'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {out_z, out_status, out_tag}); end
    checks++; if (sticky_flags !== 8'h00) begin errors++; $display("FAIL reset_sticky got=%h exp=00", sticky_flags); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_pass();
    drive(1'b1, 32'h40C00000, 8'h00, 4'd3, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_z !== 32'h40C00000) begin errors++; $display("FAIL single_z got=%h exp=40c00000", out_z); end
    checks++; if (out_status !== 8'h00 || out_tag !== 4'd3) begin errors++; $display("FAIL single_status_tag got=%h/%0d exp=00/3", out_status, out_tag); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", count); end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_count0 got=%0d/%b exp=0/0", count, out_valid); end
    checks++; if (out_z !== 32'h0) begin errors++; $display("FAIL single_z_empty got=%h exp=0", out_z); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 32'h3F800000 + (i << 20);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, w[i], 8'h00, 4'(i), 1'b0, 1'b0);
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready_%0d got=%b exp=%b", i, in_ready, (i < 4)); end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_z !== w[i] || out_tag !== 4'(i)) begin errors++; $display("FAIL fill_drain_%0d got=%h/%0d exp=%h/%0d", i, out_z, out_tag, w[i], i); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%0d/%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_full_simultaneous();
    logic [31:0] a [4];
    logic [31:0] exp_tail [3];
    logic [31:0] b;
    b = 32'hBF000001;
    for (int i = 0; i < 4; i++) a[i] = 32'h41200000 ^ i;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, a[i], 8'h00, 4'(8 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, b, 8'h00, 4'hF, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_z !== a[0]) begin errors++; $display("FAIL full_head got=%b/%h exp=0/%h", in_ready, out_z, a[0]); end
    tick();
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got=%0d/%b exp=3/1", count, in_ready); end
    checks++; if (out_z !== a[1]) begin errors++; $display("FAIL full_head2 got=%h exp=%h", out_z, a[1]); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_push_pop_count got=%0d exp=3", count); end
    in_valid = 1'b0;
    exp_tail[0] = a[2]; exp_tail[1] = a[3]; exp_tail[2] = b;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_z !== exp_tail[i]) begin errors++; $display("FAIL full_wrap_order_%0d got=%h exp=%h", i, out_z, exp_tail[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", count); end
  endtask

  task automatic test_sticky();
    drive(1'b0, 32'h0, 8'h00, 4'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h11111111, 8'h20, 4'd1, 1'b1, 1'b0);
    tick();
    checks++; if (sticky_flags !== 8'h20) begin errors++; $display("FAIL sticky_20 got=%h exp=20", sticky_flags); end
    drive(1'b1, 32'h22222222, 8'h12, 4'd2, 1'b1, 1'b0);
    tick();
    checks++; if (sticky_flags !== 8'h32) begin errors++; $display("FAIL sticky_32 got=%h exp=32", sticky_flags); end
    checks++; if (out_status !== 8'h12) begin errors++; $display("FAIL sticky_head_status got=%h exp=12", out_status); end
    drive(1'b0, 32'h0, 8'h00, 4'd0, 1'b1, 1'b1);
    tick();
    checks++; if (sticky_flags !== 8'h00) begin errors++; $display("FAIL sticky_clear got=%h exp=00", sticky_flags); end
    drive(1'b1, 32'h33333333, 8'h04, 4'd3, 1'b1, 1'b1);
    tick();
    checks++; if (sticky_flags !== 8'h04) begin errors++; $display("FAIL sticky_set_wins got=%h exp=04", sticky_flags); end
    drive(1'b0, 32'h0, 8'h00, 4'd0, 1'b1, 1'b0);
    tick();
    checks++; if (sticky_flags !== 8'h04 || count !== 3'd0) begin errors++; $display("FAIL sticky_pop_keeps got=%h/%0d exp=04/0", sticky_flags, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA5A50000 + i, 8'h01, 4'(i), 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL areset_state got=%b/%0d exp=0/0", out_valid, count); end
    checks++; if (in_ready !== 1'b1 || sticky_flags !== 8'h00) begin errors++; $display("FAIL areset_ready_sticky got=%b/%h exp=1/00", in_ready, sticky_flags); end
    checks++; if (out_z !== 32'h0) begin errors++; $display("FAIL areset_z got=%h exp=0", out_z); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [43:0] q [$];
    logic [7:0]  m_sticky;
    logic        v, ordy, clr, do_push, do_pop;
    logic [31:0] z;
    logic [7:0]  st;
    logic [3:0]  tg;
    logic [43:0] exp_head;
    int          err_before;
    m_sticky = 8'h00;
    for (int c = 0; c < 600; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      z    = $urandom;
      st   = ($urandom_range(0, 3) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
      tg   = 4'($urandom_range(0, 15));
      drive(v, z, st, tg, ordy, clr);
      exp_head = (q.size() != 0) ? q[0] : 44'd0;
      err_before = errors;
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, q.size()); end
      checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_in_ready c=%0d got=%b", c, in_ready); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_out_valid c=%0d got=%b", c, out_valid); end
      checks++; if ({out_z, out_status, out_tag} !== exp_head) begin errors++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, {out_z, out_status, out_tag}, exp_head); end
      checks++; if (sticky_flags !== m_sticky) begin errors++; $display("FAIL rand_sticky c=%0d got=%h exp=%h", c, sticky_flags, m_sticky); end
      do_push = v && (q.size() < DEPTH);
      do_pop  = ordy && (q.size() != 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({z, st, tg});
      m_sticky = (clr ? 8'h00 : m_sticky) | (do_push ? st : 8'h00);
      tick();
      if (errors - err_before > 0 && errors > 20) break;
    end
    drive(1'b0, 32'h0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
  task automatic test_irq();
    flag_mask = 8'h04;
    drive(1'b0, 32'h0, 8'h00, 4'd0, 1'b1, 1'b1);
    tick();
    tick();
    checks++; if (flag_irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", flag_irq); end
    drive(1'b1, 32'h12345678, 8'h04, 4'd1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (sticky_flags !== 8'h04 || flag_irq !== 1'b0) begin errors++; $display("FAIL irq_lag got=%h/%b exp=04/0", sticky_flags, flag_irq); end
    tick();
    checks++; if (flag_irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", flag_irq); end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 8'h00 || flag_irq !== 1'b1) begin errors++; $display("FAIL irq_clr_lag got=%h/%b exp=00/1", sticky_flags, flag_irq); end
    tick();
    checks++; if (flag_irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", flag_irq); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h00, 4'd0, 1'b0, 1'b0);
`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
    flag_mask = 8'h00;
`endif
    test_reset();
    test_single_pass();
    test_fill_backpressure();
    test_full_simultaneous();
    test_sticky();
    test_async_reset();
    test_random();
`ifdef FP_MULT_RESULT_FIFO_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mult_result_fifo.md
Name: fp_mult_result_fifo

Overview:
- Downstream consumer of the single-precision FP multiplier instance in the 16-bit pipelined processor.
- Captures each product word, its 8-bit status, and a destination tag into a small synchronous FIFO, so the writeback stage can apply backpressure without stalling the multiplier issue logic.
- Keeps a sticky accumulation of the exception status bits, which the control unit reads and clears.

Parameters:
- SIG_WIDTH, 23: significand width of the product word; matches the multiplier.
- EXP_WIDTH, 8: exponent width of the product word.
- TAG_WIDTH, 4: width of the destination-register tag carried alongside each result.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: a product word is presented.
- in_ready, output, 1: FIFO can accept an entry.
- in_z, input, SIG_WIDTH+EXP_WIDTH+1: product word from the multiplier.
- in_status, input, 8: multiplier status byte.
- in_tag, input, TAG_WIDTH: destination tag.
- out_valid, output, 1: head entry is available.
- out_ready, input, 1: writeback accepts the head entry.
- out_z, output, SIG_WIDTH+EXP_WIDTH+1: head product word.
- out_status, output, 8: head status byte.
- out_tag, output, TAG_WIDTH: head tag.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- flag_clr, input, 1: clear the sticky flags.
- sticky_flags, output, 8: OR of the status bytes of all entries pushed since the last clear or reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst). All state (write/read pointers, count, sticky_flags) goes to 0 while rst is high.
- Outputs during reset: in_ready=1, out_valid=0, out_z/out_status/out_tag=0.
- Push: occurs when in_valid && in_ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH), decoded from registered count. There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- out_z/out_status/out_tag show mem[rd_ptr] when out_valid=1, and are forced to 0 when out_valid=0.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no same-cycle bypass when empty.
- Count update per cycle: push only → +1; pop only → −1; push and pop together → unchanged, with both pointers advancing.
- Full: in_ready=0, so in_valid is ignored and no entry is overwritten. A pop while full frees a slot; in_ready rises the following cycle.
- Empty: out_ready is ignored and pointers do not move.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.
- Sticky flags: next = (flag_clr ? 0 : sticky_flags) | (push ? in_status : 0). A status byte pushed in the same cycle as flag_clr is kept (set wins over clear). Popping never affects sticky_flags.
- Status byte layout, unchanged from the multiplier:
  - bit0 zero, bit1 infinity, bit2 invalid, bit3 tiny
  - bit4 huge, bit5 inexact, bit6 hugeint, bit7 reserved
- Data integrity: entries are stored and returned bit-exact. No rounding, NaN canonicalisation or reordering; strict FIFO order.
- Reset mid-operation: all entries are discarded immediately (asynchronous). Stale data in mem is never presented, because out_valid=0 forces the outputs to 0.

Optional Feature:
- Macro: FP_MULT_RESULT_FIFO_IRQ_EN.
- Defined: adds an 8-bit input flag_mask and a 1-bit output flag_irq. flag_irq is a registered |(sticky_flags & flag_mask): it rises one cycle after sticky_flags gains a masked bit, and falls one cycle after flag_clr clears it. It resets to 0.
- Undefined: neither port exists, no extra logic is built, and all other behaviour is identical.

Test Plan:
- Single pass: push in_z=0x40C00000, status=0x00, tag=3 into an empty FIFO with out_ready=1 → out_valid=1 next cycle with 0x40C00000/0x00/3; count goes 0→1→0.
- Fill and backpressure: push 5 distinct words with out_ready=0 and DEPTH=4 → in_ready=0 after the 4th push, the 5th word is not stored, count=4; drain returns words 1..4 in order.
- Full simultaneous: while full, hold out_ready=1 with in_valid=1 → the pop happens, in_ready=1 the next cycle, and the new word is accepted that cycle; order is preserved across the pointer wrap.
- Sticky flags: push status 0x20, then 0x12, then pulse flag_clr alone → sticky_flags=0x20, then 0x32, then 0x00. Pushing 0x04 with flag_clr=1 in the same cycle → sticky_flags=0x04.
- Async reset: assert rst mid-cycle with 3 entries held → out_valid=0, count=0, in_ready=1 and sticky_flags=0 immediately, without waiting for a clk edge.
- IRQ (macro defined): flag_mask=0x04, push status 0x04 → flag_irq=1 one cycle after sticky_flags sets; flag_clr → flag_irq=0 one cycle later.
